// File: rtl/qea_host_sequencer.sv
// qea_host_sequencer: drives one complete QEA run.
// It loads the context, seeds |0..0>, starts, times the run and streams out the state.
module qea_host_sequencer #(
  parameter int PE_NUM_WIDTH            = 2,
  parameter int PE_NUM                  = 4,
  parameter int DATA_WIDTH              = 32,
  parameter int STATE_DATA_WIDTH        = 64,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_CONTEXT_DATA_WIDTH = 64,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int NUM_FRAC_BIT            = 30,
  parameter int RD_LATENCY              = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_go,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH:0]     i_ins_num,
  input  logic                                 s_ctx_valid,
  output logic                                 s_ctx_ready,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   s_ctx_data,
  output logic                                 m_state_valid,
  input  logic                                 m_state_ready,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   m_state_data,
  output logic                                 m_state_last,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_err,
  output logic [31:0]                          o_cycle_count,
  output logic                                 o_start,
  output logic [MAX_QBIT_WIDTH-1:0]            o_qbit_num,
  output logic                                 o_ctx_en,
  output logic                                 o_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
  output logic                                 o_state_ena,
  output logic                                 o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
  input  logic                                 i_complete,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dout
);

  localparam int SW  = PE_NUM * STATE_DATA_WIDTH;
  localparam int SAW = STATE_ADDR_WIDTH;
  localparam int CAW = GATE_CONTEXT_ADDR_WIDTH;
  localparam int QW  = MAX_QBIT_WIDTH;

  localparam logic [QW-1:0] QMIN = QW'(PE_NUM_WIDTH);
  localparam logic [QW-1:0] QMAX = QW'(SAW + PE_NUM_WIDTH);

  localparam logic [STATE_DATA_WIDTH-1:0] AMP_ONE =
    {DATA_WIDTH'(1 << NUM_FRAC_BIT), DATA_WIDTH'(0)};
  localparam logic [SW-1:0] WORD0 =
    {AMP_ONE, {(SW - STATE_DATA_WIDTH){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_CTX,
    S_INIT,
    S_START,
    S_RUN,
    S_READ,
    S_DONE
  } state_t;

  state_t state;

  logic [CAW:0]          ins_num;
  logic [CAW:0]          ctx_cnt;
  logic [SAW-1:0]        last_addr;
  logic [SAW:0]          rd_cnt;
  logic [SAW:0]          ret_cnt;
  logic                  run_first;

  logic [RD_LATENCY-1:0] rv;
  logic [1:0]            pend;
  logic [1:0]            buf_cnt;
  logic [SW-1:0]         buf0;
  logic [SW-1:0]         buf1;
  logic                  last0;
  logic                  last1;

  logic                  go_bad;
  logic [SAW:0]          cmd_words;
  logic                  ctx_hs;
  logic                  ret;
  logic                  ret_last;
  logic                  has_buf;
  logic                  pop;
  logic                  pop_buf;
  logic                  push;
  logic [1:0]            cnt_n;
  logic [1:0]            tgt;
  logic [2:0]            occ;
  logic                  issue;

  // Command decode, handshakes and read-credit accounting.
  always_comb begin
    go_bad    = (i_qbit_num < QMIN) || (i_qbit_num > QMAX);
    cmd_words = (SAW+1)'(1) << (i_qbit_num - QMIN);
    s_ctx_ready = (state == S_LOAD_CTX);
    o_busy    = (state != S_IDLE);
    ctx_hs    = s_ctx_valid & s_ctx_ready;
    ret       = rv[RD_LATENCY-1];
    ret_last  = (ret_cnt == {1'b0, last_addr});
    has_buf   = (buf_cnt != 2'd0);
    m_state_valid = has_buf | ret;
    m_state_data  = has_buf ? buf0 : i_state_dout;
    m_state_last  = has_buf ? last0 : ret_last;
    pop       = m_state_valid & m_state_ready;
    pop_buf   = pop & has_buf;
    push      = ret & (has_buf | ~m_state_ready);
    cnt_n     = buf_cnt + {1'b0, push} - {1'b0, pop_buf};
    tgt       = pop_buf ? buf_cnt - 2'd1 : buf_cnt;
    occ       = {1'b0, cnt_n} + {1'b0, pend} - {2'b0, ret};
    issue     = (state == S_READ) &&
                (rd_cnt <= {1'b0, last_addr}) &&
                (occ < 3'd2);
  end

  // Read return pipe and 2-entry output buffer; data bypasses it when ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv      <= '0;
      pend    <= '0;
      buf_cnt <= '0;
      buf0    <= '0;
      buf1    <= '0;
      last0   <= 1'b0;
      last1   <= 1'b0;
      ret_cnt <= '0;
    end else begin
      rv[0] <= o_state_ena & ~o_state_wea;
      for (int i = 1; i < RD_LATENCY; i++) rv[i] <= rv[i-1];
      pend    <= pend - {1'b0, ret} + {1'b0, issue};
      buf_cnt <= cnt_n;
      if (state == S_IDLE) ret_cnt <= '0;
      else if (ret) ret_cnt <= ret_cnt + 1'b1;
      if (pop_buf) begin
        buf0  <= buf1;
        last0 <= last1;
      end
      if (push) begin
        if (tgt == 2'd0) begin
          buf0  <= i_state_dout;
          last0 <= ret_last;
        end else begin
          buf1  <= i_state_dout;
          last1 <= ret_last;
        end
      end
    end
  end

  // Main sequencer; every QEA-facing output is a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      ins_num       <= '0;
      ctx_cnt       <= '0;
      last_addr     <= '0;
      rd_cnt        <= '0;
      run_first     <= 1'b0;
      o_done        <= 1'b0;
      o_err         <= 1'b0;
      o_cycle_count <= '0;
      o_start       <= 1'b0;
      o_qbit_num    <= '0;
      o_ctx_en      <= 1'b0;
      o_ctx_wea     <= 1'b0;
      o_ctx_addr    <= '0;
      o_ctx_data    <= '0;
      o_state_ena   <= 1'b0;
      o_state_wea   <= 1'b0;
      o_state_addra <= '0;
      o_state_dina  <= '0;
    end else begin
      o_ctx_en    <= 1'b0;
      o_ctx_wea   <= 1'b0;
      o_err       <= 1'b0;
      o_done      <= 1'b0;
      o_start     <= 1'b0;
      o_state_ena <= 1'b0;
      o_state_wea <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (i_go) begin
            if (go_bad) begin
              o_err <= 1'b1;
            end else begin
              o_qbit_num <= i_qbit_num;
              ins_num    <= i_ins_num;
              last_addr  <= SAW'(cmd_words - 1'b1);
              ctx_cnt    <= '0;
              if (i_ins_num == '0) begin
                state         <= S_INIT;
                o_state_ena   <= 1'b1;
                o_state_wea   <= 1'b1;
                o_state_addra <= '0;
                o_state_dina  <= WORD0;
              end else begin
                state <= S_LOAD_CTX;
              end
            end
          end
        end
        S_LOAD_CTX: begin
          if (ctx_hs) begin
            o_ctx_en   <= 1'b1;
            o_ctx_wea  <= 1'b1;
            o_ctx_addr <= ctx_cnt[CAW-1:0];
            o_ctx_data <= s_ctx_data;
            ctx_cnt    <= ctx_cnt + 1'b1;
            if (ctx_cnt == ins_num - 1'b1) begin
              state         <= S_INIT;
              o_state_ena   <= 1'b1;
              o_state_wea   <= 1'b1;
              o_state_addra <= '0;
              o_state_dina  <= WORD0;
            end
          end
        end
        S_INIT: begin
          if (o_state_addra == last_addr) begin
            state         <= S_START;
            o_start       <= 1'b1;
            o_cycle_count <= 32'd1;
          end else begin
            o_state_ena   <= 1'b1;
            o_state_wea   <= 1'b1;
            o_state_addra <= o_state_addra + 1'b1;
            o_state_dina  <= '0;
          end
        end
        S_START: begin
          state     <= S_RUN;
          run_first <= 1'b1;
        end
        S_RUN: begin
          if (run_first) begin
            run_first <= 1'b0;
          end else if (i_complete) begin
            state  <= S_READ;
            rd_cnt <= '0;
          end else begin
            o_cycle_count <= o_cycle_count + 32'd1;
          end
        end
        S_READ: begin
          if (issue) begin
            o_state_ena   <= 1'b1;
            o_state_addra <= rd_cnt[SAW-1:0];
            rd_cnt        <= rd_cnt + 1'b1;
          end
          if (pop && m_state_last) begin
            state  <= S_DONE;
            o_done <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qea_host_sequencer.sv
// tb_qea_host_sequencer: directed bench with QEA RAM/complete model.
// Monitors tally per-run errors; the initial block asserts on them.
module tb_qea_host_sequencer;

  localparam logic [255:0] WORD0 = {64'h40000000_00000000, 192'h0};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_go = 1'b0;
  logic [5:0]   i_qbit_num = '0;
  logic [16:0]  i_ins_num = '0;
  logic         s_ctx_valid = 1'b0;
  logic         s_ctx_ready;
  logic [63:0]  s_ctx_data = '0;
  logic         m_state_valid;
  logic         m_state_ready = 1'b1;
  logic [255:0] m_state_data;
  logic         m_state_last;
  logic         o_busy, o_done, o_err;
  logic [31:0]  o_cycle_count;
  logic         o_start;
  logic [5:0]   o_qbit_num;
  logic         o_ctx_en, o_ctx_wea;
  logic [15:0]  o_ctx_addr;
  logic [63:0]  o_ctx_data;
  logic         o_state_ena, o_state_wea;
  logic [15:0]  o_state_addra;
  logic [255:0] o_state_dina;
  logic         i_complete = 1'b0;
  logic [255:0] i_state_dout;

  qea_host_sequencer dut (
    .clk(clk), .rst_n(rst_n), .i_go(i_go),
    .i_qbit_num(i_qbit_num), .i_ins_num(i_ins_num),
    .s_ctx_valid(s_ctx_valid), .s_ctx_ready(s_ctx_ready),
    .s_ctx_data(s_ctx_data),
    .m_state_valid(m_state_valid), .m_state_ready(m_state_ready),
    .m_state_data(m_state_data), .m_state_last(m_state_last),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_cycle_count(o_cycle_count), .o_start(o_start),
    .o_qbit_num(o_qbit_num),
    .o_ctx_en(o_ctx_en), .o_ctx_wea(o_ctx_wea),
    .o_ctx_addr(o_ctx_addr), .o_ctx_data(o_ctx_data),
    .o_state_ena(o_state_ena), .o_state_wea(o_state_wea),
    .o_state_addra(o_state_addra), .o_state_dina(o_state_dina),
    .i_complete(i_complete), .i_state_dout(i_state_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ctx_word(input int k);
    return {32'hC0DE0000 + 32'(k), ~32'(k)};
  endfunction

  function automatic logic [255:0] state_pat(input int i, input int s);
    return {8{32'h9E370000 + 32'(s * 256 + i)}};
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // QEA state RAM: 1-cycle read latency, plus a whole-array
  // overwrite that stands in for the QEA computing a result.
  logic [255:0] smem [64];
  logic scribble = 1'b0;
  int   salt = 0;
  int   exp_words = 64;
  always @(posedge clk) begin
    if (scribble) begin
      for (int i = 0; i < 64; i++) smem[i] <= state_pat(i, salt);
    end else if (o_state_ena) begin
      if (o_state_wea) smem[o_state_addra[5:0]] <= o_state_dina;
      else i_state_dout <= smem[o_state_addra[5:0]];
    end
  end

  int ctx_n, ctx_ord_err, ctx_dat_err, ctx_first, ctx_last;
  int ini_n, ini_err, ini_first, ini_last;
  int rb_n, rb_err, rb_first, rb_last, stab_err;
  int start_n, done_n;
  logic [255:0] hold_d;
  logic hold_v = 1'b0;

  // Per-run monitors, cleared by an accepted command.
  always @(posedge clk) begin
    if (i_go && !o_busy) begin
      ctx_n <= 0; ctx_ord_err <= 0; ctx_dat_err <= 0;
      ini_n <= 0; ini_err <= 0;
      rb_n <= 0; rb_err <= 0; stab_err <= 0;
      start_n <= 0; done_n <= 0;
      hold_v <= 1'b0;
    end else begin
      if (o_ctx_en && o_ctx_wea) begin
        if (ctx_n == 0) ctx_first <= cyc;
        ctx_last <= cyc;
        if (o_ctx_addr != 16'(ctx_n)) ctx_ord_err <= ctx_ord_err + 1;
        if (o_ctx_data !== ctx_word(ctx_n)) ctx_dat_err <= ctx_dat_err + 1;
        ctx_n <= ctx_n + 1;
      end
      if (o_state_ena && o_state_wea) begin
        if (ini_n == 0) ini_first <= cyc;
        ini_last <= cyc;
        if (o_state_addra != 16'(ini_n) ||
            o_state_dina !== (ini_n == 0 ? WORD0 : 256'h0))
          ini_err <= ini_err + 1;
        ini_n <= ini_n + 1;
      end
      if (o_start) start_n <= start_n + 1;
      if (o_done) done_n <= done_n + 1;
      if (m_state_valid && m_state_ready) begin
        if (rb_n == 0) rb_first <= cyc;
        rb_last <= cyc;
        if (m_state_data !== state_pat(rb_n, salt) ||
            m_state_last !== (rb_n == exp_words - 1))
          rb_err <= rb_err + 1;
        rb_n <= rb_n + 1;
      end
      if (hold_v && (!m_state_valid || m_state_data !== hold_d))
        stab_err <= stab_err + 1;
      hold_v <= m_state_valid && !m_state_ready;
      hold_d <= m_state_data;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [255:0] obs,
                      input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [5:0] q, input logic [16:0] n);
    i_go = 1'b1;
    i_qbit_num = q;
    i_ins_num = n;
    tick();
    i_go = 1'b0;
  endtask

  task automatic feed(input int n, input bit stall);
    int k = 0;
    int g = 0;
    bit hs;
    while (k < n && g < 5000) begin
      s_ctx_valid = stall ? (g % 2 == 0) : 1'b1;
      s_ctx_data = ctx_word(k);
      hs = s_ctx_valid && s_ctx_ready;
      tick();
      if (hs) k++;
      g++;
    end
    s_ctx_valid = 1'b0;
    chk("ctx_beats_accepted", 32'(k), 32'(n));
  endtask

  // QEA model: drop a stale complete after the guard cycle, compute,
  // then raise complete in cycle START+m.
  task automatic run_qea(input int m);
    int g = 0;
    while (!o_start && g < 5000) begin
      tick();
      g++;
    end
    chk("start_seen", 32'(o_start), 32'd1);
    chkw("ram_word0_init", smem[0], WORD0);
    chkw("ram_lastword_init", smem[exp_words-1],
         exp_words == 1 ? WORD0 : 256'h0);
    tick();
    tick();
    i_complete = 1'b0;
    scribble = 1'b1;
    tick();
    scribble = 1'b0;
    repeat (m - 3) tick();
    i_complete = 1'b1;
  endtask

  task automatic drain(input bit rnd);
    int g = 0;
    while (!o_done && g < 2000) begin
      m_state_ready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
      tick();
      g++;
    end
    m_state_ready = 1'b1;
    chk("done_seen", 32'(o_done), 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_ctx_ready", 32'(s_ctx_ready), 32'd0);
    chk("rst_strobes", 32'({o_ctx_en, o_state_ena, o_start, o_done, o_err}), 32'd0);
    chk("rst_mvalid", 32'(m_state_valid), 32'd0);
    chk("rst_cycle_count", o_cycle_count, 32'd0);
    chk("rst_qbit", 32'(o_qbit_num), 32'd0);
    rst_n = 1'b1;
    tick();

    go(6'd1, 17'd5);
    chk("bad_lo_err", 32'(o_err), 32'd1);
    chk("bad_lo_idle", 32'(o_busy), 32'd0);
    tick();
    chk("err_pulse_len", 32'(o_err), 32'd0);
    go(6'd19, 17'd5);
    chk("bad_hi_err", 32'(o_err), 32'd1);
    chk("bad_hi_idle", 32'(o_busy), 32'd0);

    go(6'd8, 17'd10);
    s_ctx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_ctx_data = ctx_word(i);
      tick();
    end
    chk("pre_rst_ctx_en", 32'(o_ctx_en), 32'd1);
    chk("pre_rst_busy", 32'(o_busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_ctx_ready", 32'(s_ctx_ready), 32'd0);
    chk("async_ctx_en", 32'(o_ctx_en), 32'd0);
    chk("async_busy", 32'(o_busy), 32'd0);
    s_ctx_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 32'(o_busy), 32'd0);

    salt = 1;
    exp_words = 64;
    go(6'd8, 17'd1041);
    chk("A_load_ready", 32'(s_ctx_ready), 32'd1);
    feed(1041, 1'b0);
    run_qea(501);
    drain(1'b0);
    tick();
    chk("A_ctx_n", 32'(ctx_n), 32'd1041);
    chk("A_ctx_order", 32'(ctx_ord_err), 32'd0);
    chk("A_ctx_data", 32'(ctx_dat_err), 32'd0);
    chk("A_ctx_span", 32'(ctx_last - ctx_first + 1), 32'd1041);
    chk("A_init_n", 32'(ini_n), 32'd64);
    chk("A_init_err", 32'(ini_err), 32'd0);
    chk("A_init_span", 32'(ini_last - ini_first + 1), 32'd64);
    chk("A_start_n", 32'(start_n), 32'd1);
    chk("A_cycle_count", o_cycle_count, 32'd500);
    chk("A_rb_n", 32'(rb_n), 32'd64);
    chk("A_rb_err", 32'(rb_err), 32'd0);
    chk("A_rb_span", 32'(rb_last - rb_first + 1), 32'd64);
    chk("A_done_n", 32'(done_n), 32'd1);
    chk("A_idle", 32'(o_busy), 32'd0);
    chk("A_qbit", 32'(o_qbit_num), 32'd8);

    salt = 2;
    go(6'd8, 17'd1041);
    feed(1041, 1'b1);
    go(6'd1, 17'd0);
    chk("B_busy_go_no_err", 32'(o_err), 32'd0);
    chk("B_busy_go_busy", 32'(o_busy), 32'd1);
    run_qea(101);
    drain(1'b1);
    tick();
    chk("B_ctx_n", 32'(ctx_n), 32'd1041);
    chk("B_ctx_order", 32'(ctx_ord_err), 32'd0);
    chk("B_ctx_data", 32'(ctx_dat_err), 32'd0);
    chk("B_init_n", 32'(ini_n), 32'd64);
    chk("B_cycle_count", o_cycle_count, 32'd100);
    chk("B_rb_n", 32'(rb_n), 32'd64);
    chk("B_rb_err", 32'(rb_err), 32'd0);
    chk("B_stable", 32'(stab_err), 32'd0);
    chk("B_done_n", 32'(done_n), 32'd1);

    salt = 3;
    exp_words = 1;
    go(6'd2, 17'd0);
    chk("C_init_now", 32'({o_state_ena, o_state_wea}), 32'd3);
    chk("C_init_addr", 32'(o_state_addra), 32'd0);
    chk("C_no_ctx_ready", 32'(s_ctx_ready), 32'd0);
    run_qea(11);
    drain(1'b0);
    tick();
    chk("C_ctx_n", 32'(ctx_n), 32'd0);
    chk("C_init_n", 32'(ini_n), 32'd1);
    chk("C_cycle_count", o_cycle_count, 32'd10);
    chk("C_rb_n", 32'(rb_n), 32'd1);
    chk("C_rb_err", 32'(rb_err), 32'd0);
    chk("C_idle", 32'(o_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
